ft245_sync_responder: RTL and testbench

FT245_SYNC_RESPONDER -- requirements
Module: ft245_sync_responder

---
 rtl/ft245_sync_responder_pkg.sv | 18 +
 rtl/ft245_sync_responder_fifo.sv | 62 ++++++
 rtl/ft245_sync_responder.sv | 142 ++++++++++++++
 tb/tb_ft245_sync_responder.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft245_sync_responder_pkg.sv
// Shared types and constants for the FT245 synchronous-FIFO device emulator.
// Bus-state encoding, packet-gap length and proto_err bit positions live here.
package ft245_sync_responder_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_TURN,
        BUS_READ,
        BUS_WRITE
    } bus_state_e;

    localparam int unsigned PKT_GAP_BYTES = 64;

    localparam int unsigned ERR_CONTENTION = 2;
    localparam int unsigned ERR_RD_NO_OE   = 1;
    localparam int unsigned ERR_OVERFLOW   = 0;

endpackage

// File: rtl/ft245_sync_responder_fifo.sv
// First-word-fall-through byte FIFO: head visible combinationally, pop/push take effect on the clock edge.
// Push is refused when full unless a pop happens on the same edge; pop is ignored when empty.
module fwft_byte_fifo
    import ft245_sync_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    push_i,
    input  logic [7:0]              push_dat_i,
    input  logic                    pop_i,
    output logic [7:0]              head_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty, full, push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign pop_ok  = pop_i & ~empty;
    assign push_ok = push_i & (~full | pop_ok);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push_ok && !pop_ok) count_d = count_q + CNT_ONE;
        if (pop_ok && !push_ok) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/ft245_sync_responder.sv
// Emulates the device side of an FT245 synchronous FIFO bus: host byte streams on one side, FPGA strobes on the other.
// Zero-latency flags/head; host side uses valid/ready, FPGA side is throttled by rxf_n/txe_n plus a packet gap every 64 writes.
module ft245_sync_responder
    import ft245_sync_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNTW  = 16
) (
    input  logic            clk,
    input  logic            res,
    input  logic [7:0]      host_tx_data,
    input  logic            host_tx_valid,
    output logic            host_tx_ready,
    output logic [7:0]      host_rx_data,
    output logic            host_rx_valid,
    input  logic            host_rx_ready,
    output logic            ftdi_rxf_n,
    output logic            ftdi_txe_n,
    input  logic            ftdi_rd_n,
    input  logic            ftdi_oe_n,
    input  logic            ftdi_wr_n,
    input  logic [7:0]      ftdi_data_in,
    output logic [7:0]      ftdi_data_out,
    output logic            ftdi_data_oe,
    output logic [CNTW-1:0] rx_count,
    output logic [CNTW-1:0] tx_count,
    output logic [2:0]      proto_err
);

    localparam int unsigned CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam int unsigned GAPW     = $clog2(PKT_GAP_BYTES);
    localparam logic [GAPW-1:0] GAP_LAST = GAPW'(PKT_GAP_BYTES - 1);
    localparam logic [GAPW-1:0] GAP_ONE  = GAPW'(1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    bus_state_e      state_q, state_d;
    logic [GAPW-1:0] gap_cnt_q, gap_cnt_d;
    logic            gap_q, gap_d;
    logic [CNTW-1:0] rx_count_q, rx_count_d;
    logic [CNTW-1:0] tx_count_q, tx_count_d;
    logic [2:0]      err_q, err_d;

    logic [CW-1:0]   rx_cnt, tx_cnt;
    logic [7:0]      rx_head, tx_head;
    logic            rx_empty, rx_full, tx_empty, tx_full;
    logic            host_push, host_pop, rx_pop, tx_push, oe_held;

    fwft_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk        (clk),
        .res        (res),
        .push_i     (host_push),
        .push_dat_i (host_tx_data),
        .pop_i      (rx_pop),
        .head_o     (rx_head),
        .count_o    (rx_cnt)
    );

    fwft_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk        (clk),
        .res        (res),
        .push_i     (tx_push),
        .push_dat_i (ftdi_data_in),
        .pop_i      (host_pop),
        .head_o     (tx_head),
        .count_o    (tx_cnt)
    );

    assign rx_empty      = (rx_cnt == '0);
    assign rx_full       = (rx_cnt == FULL_CNT);
    assign tx_empty      = (tx_cnt == '0);
    assign tx_full       = (tx_cnt == FULL_CNT);

    assign host_tx_ready = ~rx_full;
    assign host_push     = host_tx_valid & host_tx_ready;
    assign host_rx_valid = ~tx_empty;
    assign host_rx_data  = tx_head;
    assign host_pop      = host_rx_valid & host_rx_ready;

    assign ftdi_rxf_n    = rx_empty;
    assign ftdi_txe_n    = tx_full | gap_q;
    assign ftdi_data_out = rx_head;
    assign ftdi_data_oe  = ~ftdi_oe_n;

    assign rx_count      = rx_count_q;
    assign tx_count      = tx_count_q;
    assign proto_err     = err_q;

    // TURN/READ are only reachable with oe_n low, so they also mean "oe_n was low on the previous edge".
    assign oe_held = (state_q == BUS_TURN) || (state_q == BUS_READ);

    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = '0;
        gap_d      = 1'b0;
        rx_count_d = rx_count_q;
        tx_count_d = tx_count_q;
        err_d      = err_q;
        rx_pop     = ~ftdi_rd_n & ~ftdi_oe_n & ~rx_empty & oe_held;
        tx_push    = ~ftdi_wr_n & ~ftdi_txe_n & ftdi_oe_n;

        if (ftdi_oe_n) begin
            state_d = ftdi_wr_n ? BUS_IDLE : BUS_WRITE;
        end else begin
            case (state_q)
                BUS_IDLE, BUS_WRITE: state_d = BUS_TURN;
                BUS_TURN:            if (!ftdi_rd_n) state_d = BUS_READ;
                default:             state_d = state_q;
            endcase
        end

        if (!ftdi_wr_n && !ftdi_oe_n) err_d[ERR_CONTENTION] = 1'b1;
        if (!ftdi_rd_n && !oe_held)   err_d[ERR_RD_NO_OE]   = 1'b1;
        if (!ftdi_wr_n && ftdi_txe_n) err_d[ERR_OVERFLOW]   = 1'b1;

        if (rx_pop)  rx_count_d = rx_count_q + CNT_ONE;
        if (tx_push) begin
            tx_count_d = tx_count_q + CNT_ONE;
            if (gap_cnt_q == GAP_LAST) gap_d = 1'b1;
            else                       gap_cnt_d = gap_cnt_q + GAP_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= BUS_IDLE;
            gap_cnt_q  <= '0;
            gap_q      <= 1'b0;
            rx_count_q <= '0;
            tx_count_q <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            gap_q      <= gap_d;
            rx_count_q <= rx_count_d;
            tx_count_q <= tx_count_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_ft245_sync_responder.sv
// Bench for ft245_sync_responder: vector table, directed multi-cycle sequences and randomized traffic
// checked every cycle against a queue-based model of the device's byte streams and error rules.
module tb_ft245_sync_responder;

    localparam int DEPTH = 16;
    localparam int CNTW  = 16;
    localparam int GAP   = 64;

    logic            clk = 1'b0;
    logic            res;
    logic [7:0]      host_tx_data;
    logic            host_tx_valid;
    logic            host_tx_ready;
    logic [7:0]      host_rx_data;
    logic            host_rx_valid;
    logic            host_rx_ready;
    logic            ftdi_rxf_n, ftdi_txe_n;
    logic            ftdi_rd_n, ftdi_oe_n, ftdi_wr_n;
    logic [7:0]      ftdi_data_in, ftdi_data_out;
    logic            ftdi_data_oe;
    logic [CNTW-1:0] rx_count, tx_count;
    logic [2:0]      proto_err;

    always #5 clk = ~clk;

    ft245_sync_responder #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk           (clk),
        .res           (res),
        .host_tx_data  (host_tx_data),
        .host_tx_valid (host_tx_valid),
        .host_tx_ready (host_tx_ready),
        .host_rx_data  (host_rx_data),
        .host_rx_valid (host_rx_valid),
        .host_rx_ready (host_rx_ready),
        .ftdi_rxf_n    (ftdi_rxf_n),
        .ftdi_txe_n    (ftdi_txe_n),
        .ftdi_rd_n     (ftdi_rd_n),
        .ftdi_oe_n     (ftdi_oe_n),
        .ftdi_wr_n     (ftdi_wr_n),
        .ftdi_data_in  (ftdi_data_in),
        .ftdi_data_out (ftdi_data_out),
        .ftdi_data_oe  (ftdi_data_oe),
        .rx_count      (rx_count),
        .tx_count      (tx_count),
        .proto_err     (proto_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: byte queues plus a handful of flags derived from the bus rules.
    logic [7:0]      rxq[$];
    logic [7:0]      txq[$];
    logic [CNTW-1:0] m_rxc, m_txc;
    logic [2:0]      m_err;
    bit              m_prev_oe_low, m_gap, m_valid;
    int              m_run;

    initial m_valid = 1'b0;

    task automatic model_check();
        if (!m_valid) return;
        chk("rxf_n", ftdi_rxf_n, rxq.size() == 0);
        chk("txe_n", ftdi_txe_n, (txq.size() == DEPTH) || m_gap);
        chk("host_tx_ready", host_tx_ready, rxq.size() < DEPTH);
        chk("host_rx_valid", host_rx_valid, txq.size() != 0);
        chk("data_oe", ftdi_data_oe, !ftdi_oe_n);
        if (rxq.size() != 0) chk("data_out", ftdi_data_out, rxq[0]);
        if (txq.size() != 0) chk("host_rx_data", host_rx_data, txq[0]);
        chk("rx_count", rx_count, m_rxc);
        chk("tx_count", tx_count, m_txc);
        chk("proto_err", proto_err, m_err);
    endtask

    task automatic model_edge();
        bit txe_m, rx_pop, tx_push, h_push, h_pop;
        if (res) begin
            rxq.delete(); txq.delete();
            m_rxc = '0; m_txc = '0; m_err = '0;
            m_prev_oe_low = 1'b0; m_gap = 1'b0; m_run = 0; m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        txe_m   = (txq.size() == DEPTH) || m_gap;
        rx_pop  = !ftdi_rd_n && !ftdi_oe_n && m_prev_oe_low && (rxq.size() != 0);
        tx_push = !ftdi_wr_n && !txe_m && ftdi_oe_n;
        h_push  = host_tx_valid && (rxq.size() < DEPTH);
        h_pop   = host_rx_ready && (txq.size() != 0);
        if (!ftdi_wr_n && !ftdi_oe_n)     m_err[2] = 1'b1;
        if (!ftdi_rd_n && !m_prev_oe_low) m_err[1] = 1'b1;
        if (!ftdi_wr_n && txe_m)          m_err[0] = 1'b1;
        if (rx_pop) begin void'(rxq.pop_front()); m_rxc++; end
        if (h_push) rxq.push_back(host_tx_data);
        if (h_pop) void'(txq.pop_front());
        if (tx_push) begin
            txq.push_back(ftdi_data_in);
            m_txc++;
            m_run++;
            m_gap = (m_run == GAP);
            if (m_gap) m_run = 0;
        end else begin
            m_run = 0;
            m_gap = 1'b0;
        end
        m_prev_oe_low = !ftdi_oe_n;
    endtask

    // Called ~1 time unit after a rising edge with inputs already set; returns 1 unit after the next edge.
    task automatic cyc();
        #1;
        model_check();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        res = 1'b0; host_tx_valid = 1'b0; host_tx_data = 8'h00; host_rx_ready = 1'b0;
        ftdi_rd_n = 1'b1; ftdi_oe_n = 1'b1; ftdi_wr_n = 1'b1; ftdi_data_in = 8'h00;
    endtask

    task automatic reset_dut();
        idle_inputs();
        res = 1'b1;
        cyc();
        res = 1'b0;
    endtask

    typedef struct {
        logic       res, hv; logic [7:0] hd; logic hr, rd_n, oe_n, wr_n; logic [7:0] din;
        logic       e_rxf_n, e_txe_n, e_doe, e_htr, e_hrv; logic [7:0] e_dout, e_hrd;
        logic [2:0] e_err; logic [15:0] e_rxc, e_txc;
    } vec_t;

    vec_t vt[12];

    logic [7:0] got[$];
    int         gaps[$];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        //            res hv hd    hr rd oe wr din  | rxf txe doe htr hrv dout  hrd   err     rxc txc
        vt[0]  = '{1, 0, 8'h00, 0, 1, 1, 1, 8'h00, 1, 0, 0, 1, 0, 8'h00, 8'h00, 3'b000, 0, 0};
        vt[1]  = '{0, 1, 8'h11, 0, 1, 1, 1, 8'h00, 0, 0, 0, 1, 0, 8'h11, 8'h00, 3'b000, 0, 0};
        vt[2]  = '{0, 1, 8'h22, 0, 1, 1, 1, 8'h00, 0, 0, 0, 1, 0, 8'h11, 8'h00, 3'b000, 0, 0};
        vt[3]  = '{0, 0, 8'h00, 0, 1, 0, 1, 8'h00, 0, 0, 1, 1, 0, 8'h11, 8'h00, 3'b000, 0, 0};
        vt[4]  = '{0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, 1, 1, 0, 8'h22, 8'h00, 3'b000, 1, 0};
        vt[5]  = '{0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 1, 0, 1, 1, 0, 8'h00, 8'h00, 3'b000, 2, 0};
        vt[6]  = '{0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 1, 0, 1, 1, 0, 8'h00, 8'h00, 3'b000, 2, 0};
        vt[7]  = '{0, 0, 8'h00, 0, 1, 1, 0, 8'h33, 1, 0, 0, 1, 1, 8'h00, 8'h33, 3'b000, 2, 1};
        vt[8]  = '{0, 0, 8'h00, 1, 1, 1, 0, 8'h44, 1, 0, 0, 1, 1, 8'h00, 8'h44, 3'b000, 2, 2};
        vt[9]  = '{0, 0, 8'h00, 1, 1, 1, 1, 8'h00, 1, 0, 0, 1, 0, 8'h00, 8'h00, 3'b000, 2, 2};
        vt[10] = '{0, 0, 8'h00, 0, 0, 1, 1, 8'h00, 1, 0, 0, 1, 0, 8'h00, 8'h00, 3'b010, 2, 2};
        vt[11] = '{1, 0, 8'h00, 0, 1, 1, 1, 8'h00, 1, 0, 0, 1, 0, 8'h00, 8'h00, 3'b000, 0, 0};

        idle_inputs();
        res = 1'b1;

        // Vector table: each row is applied for one edge, then the post-edge outputs are compared.
        for (int i = 0; i < 12; i++) begin
            res = vt[i].res; host_tx_valid = vt[i].hv; host_tx_data = vt[i].hd; host_rx_ready = vt[i].hr;
            ftdi_rd_n = vt[i].rd_n; ftdi_oe_n = vt[i].oe_n; ftdi_wr_n = vt[i].wr_n; ftdi_data_in = vt[i].din;
            cyc();
            chk($sformatf("vec%0d rxf_n", i), ftdi_rxf_n, vt[i].e_rxf_n);
            chk($sformatf("vec%0d txe_n", i), ftdi_txe_n, vt[i].e_txe_n);
            chk($sformatf("vec%0d data_oe", i), ftdi_data_oe, vt[i].e_doe);
            chk($sformatf("vec%0d host_tx_ready", i), host_tx_ready, vt[i].e_htr);
            chk($sformatf("vec%0d host_rx_valid", i), host_rx_valid, vt[i].e_hrv);
            if (!vt[i].e_rxf_n) chk($sformatf("vec%0d data_out", i), ftdi_data_out, vt[i].e_dout);
            if (vt[i].e_hrv)    chk($sformatf("vec%0d host_rx_data", i), host_rx_data, vt[i].e_hrd);
            chk($sformatf("vec%0d proto_err", i), proto_err, vt[i].e_err);
            chk($sformatf("vec%0d rx_count", i), rx_count, vt[i].e_rxc);
            chk($sformatf("vec%0d tx_count", i), tx_count, vt[i].e_txc);
        end

        // Read burst: five bytes come out on five consecutive edges after one turnaround cycle.
        reset_dut();
        for (int i = 1; i <= 5; i++) begin
            host_tx_valid = 1'b1; host_tx_data = 8'(i);
            cyc();
        end
        host_tx_valid = 1'b0;
        ftdi_oe_n = 1'b0;
        cyc();
        ftdi_rd_n = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            #1;
            chk($sformatf("burst byte%0d", i), ftdi_data_out, 8'(i));
            cyc();
        end
        chk("burst rxf_n_after", ftdi_rxf_n, 1'b1);
        chk("burst rx_count", rx_count, 5);
        idle_inputs();
        cyc();

        // Fill TX with the host stalled, then one write too many.
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            ftdi_wr_n = 1'b0; ftdi_data_in = 8'hA0 + 8'(i);
            #1;
            chk($sformatf("fill txe_n_before%0d", i), ftdi_txe_n, 1'b0);
            cyc();
        end
        chk("fill txe_n_full", ftdi_txe_n, 1'b1);
        chk("fill tx_count16", tx_count, 16);
        ftdi_data_in = 8'hEE;
        cyc();
        chk("fill overflow_err", proto_err[0], 1'b1);
        chk("fill tx_count_hold", tx_count, 16);
        ftdi_wr_n = 1'b1;
        host_rx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk($sformatf("fill drain%0d", i), host_rx_data, 8'hA0 + 8'(i));
            cyc();
        end

        // 130-byte stream against the packet-gap rule.
        reset_dut();
        host_rx_ready = 1'b1;
        got.delete(); gaps.delete();
        begin
            int pushed = 0;
            for (int c = 0; c < 400 && pushed < 130; c++) begin
                if (ftdi_txe_n) begin
                    gaps.push_back(pushed);
                    ftdi_wr_n = 1'b1;
                end else begin
                    ftdi_wr_n = 1'b0; ftdi_data_in = 8'(pushed);
                    pushed++;
                end
                #1;
                if (host_rx_valid) got.push_back(host_rx_data);
                cyc();
            end
            chk("stream completed", pushed, 130);
        end
        ftdi_wr_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (ftdi_txe_n) gaps.push_back(130);
            if (host_rx_valid) got.push_back(host_rx_data);
            cyc();
        end
        chk("stream gap_count", gaps.size(), 2);
        if (gaps.size() >= 2) begin
            chk("stream gap1_at", gaps[0], 64);
            chk("stream gap2_at", gaps[1], 128);
        end
        chk("stream tx_count", tx_count, 130);
        chk("stream host_bytes", got.size(), 130);
        begin
            int bad = -1;
            for (int i = 0; i < got.size(); i++)
                if (bad < 0 && got[i] != 8'(i)) bad = i;
            chk("stream order_first_bad_index", bad, -1);
        end
        chk("stream no_err", proto_err, 3'b000);

        // Protocol abuse: read strobe without oe_n, then write while oe_n is asserted.
        reset_dut();
        ftdi_rd_n = 1'b0;
        cyc();
        ftdi_rd_n = 1'b1; ftdi_oe_n = 1'b0; ftdi_wr_n = 1'b0; ftdi_data_in = 8'h77;
        cyc();
        idle_inputs();
        cyc();
        chk("abuse proto_err", proto_err, 3'b110);
        chk("abuse tx_count", tx_count, 0);
        chk("abuse host_rx_valid", host_rx_valid, 1'b0);
        chk("abuse rx_count", rx_count, 0);
        cyc();
        chk("abuse err_sticky", proto_err, 3'b110);

        // Reset in the middle of a read burst with bytes still queued.
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            host_tx_valid = 1'b1; host_tx_data = 8'hC0 + 8'(i);
            cyc();
        end
        host_tx_valid = 1'b0;
        ftdi_oe_n = 1'b0;
        cyc();
        ftdi_rd_n = 1'b0;
        cyc();
        chk("midrst pre_rx_count", rx_count, 1);
        res = 1'b1;
        cyc();
        chk("midrst rxf_n", ftdi_rxf_n, 1'b1);
        chk("midrst rx_count", rx_count, 0);
        idle_inputs();
        host_tx_valid = 1'b1; host_tx_data = 8'h5A;
        cyc();
        host_tx_valid = 1'b0; ftdi_oe_n = 1'b0;
        cyc();
        ftdi_rd_n = 1'b0;
        #1;
        chk("midrst fresh_byte", ftdi_data_out, 8'h5A);
        cyc();
        chk("midrst fresh_rx_count", rx_count, 1);
        chk("midrst fresh_rxf_n", ftdi_rxf_n, 1'b1);
        idle_inputs();
        cyc();

        // Randomized traffic in read-, write- and mixed-biased phases, checked by the model each cycle.
        reset_dut();
        for (int seg = 0; seg < 75; seg++) begin
            int mode = $urandom_range(0, 2);
            for (int c = 0; c < 40; c++) begin
                res           = ($urandom_range(0, 249) == 0);
                host_tx_valid = ($urandom_range(0, 99) < 60);
                host_tx_data  = 8'($urandom);
                host_rx_ready = ($urandom_range(0, 99) < 55);
                ftdi_data_in  = 8'($urandom);
                case (mode)
                    0: begin
                        ftdi_oe_n = ($urandom_range(0, 9) == 0);
                        ftdi_rd_n = ($urandom_range(0, 3) == 0);
                        ftdi_wr_n = 1'b1;
                    end
                    1: begin
                        ftdi_oe_n = ($urandom_range(0, 19) != 0);
                        ftdi_rd_n = 1'b1;
                        ftdi_wr_n = ($urandom_range(0, 3) == 0);
                    end
                    default: begin
                        ftdi_oe_n = 1'($urandom);
                        ftdi_rd_n = 1'($urandom);
                        ftdi_wr_n = 1'($urandom);
                    end
                endcase
                cyc();
            end
        end
        idle_inputs();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
